// File: rtl/packet_buffer_pkg.sv
// Shared types and constants for the packet commit buffer.
// Contents: write/read FSM state enums, default pointer width, the
// statistics saturation value and a helper that sizes pointers for a
// given RAM depth (one extra MSB serves as the wrap bit).
package packet_buffer_pkg;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WRITE,
    W_WAIT_CRC,
    W_DROP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_LOAD,
    R_STREAM
  } rd_state_t;

  localparam int          DEPTH_RAM_DEFAULT = 4096;
  localparam int          PTR_W             = $clog2(DEPTH_RAM_DEFAULT) + 1;
  localparam logic [15:0] STAT_SAT          = 16'hFFFF;

  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pkt_desc_fifo.sv
// Descriptor FIFO holding the lengths of committed frames.
// Ports: iclk/i_rst_n (sync, active-low), i_push/i_wdata write side,
// i_pop read side with o_rdata valid the cycle after the pop,
// o_full, o_empty (registered), o_count (entries stored).
module pkt_desc_fifo
#(
  parameter int pWIDTH = 16,
  parameter int pDEPTH = 64
) (
  input  logic                    iclk,
  input  logic                    i_rst_n,
  input  logic                    i_push,
  input  logic [pWIDTH-1:0]       i_wdata,
  input  logic                    i_pop,
  output logic [pWIDTH-1:0]       o_rdata,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [$clog2(pDEPTH):0] o_count
);
  localparam int            P_AW    = $clog2(pDEPTH);
  localparam logic [P_AW:0] P_DEPTH = (P_AW+1)'(pDEPTH);

  logic [pWIDTH-1:0] r_mem [pDEPTH];
  logic [pWIDTH-1:0] r_rdata;
  logic [P_AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [P_AW:0]     r_count, w_count_next;
  logic              r_empty;
  logic              w_push_ok, w_pop_ok;

  assign o_full    = (r_count == P_DEPTH);
  assign o_empty   = r_empty;
  assign o_count   = r_count;
  assign o_rdata   = r_rdata;
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~r_empty;

  // Push and pop in the same cycle leave the count unchanged.
  always_comb begin
    w_count_next = r_count;
    if (w_push_ok && !w_pop_ok)
      w_count_next = r_count + (P_AW+1)'(1);
    else if (!w_push_ok && w_pop_ok)
      w_count_next = r_count - (P_AW+1)'(1);
  end

  always_ff @(posedge iclk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + P_AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + P_AW'(1);
      r_count <= w_count_next;
      r_empty <= (w_count_next == '0);
    end
  end

  always_ff @(posedge iclk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
    if (w_pop_ok)  r_rdata <= r_mem[r_rd_ptr];
  end

endmodule

// File: rtl/packet_commit_buffer.sv
// Store-and-forward RX buffer: frames are written speculatively into a
// circular RAM, committed on a good CRC verdict or rolled back otherwise,
// then streamed out frame by frame with the length presented alongside.
// Ports: iclk, i_rst_n (sync, active-low); RX side idv/irx_d/irx_er with
// icrc_valid/icrc_ok verdict; read stream o_valid/i_ready/o_data/o_last/
// o_len; status oempty, ofull, o_pkt_cnt, o_drop_cnt.
// Macro PKT_BUF_STATS_EN: when defined the two counters are live 16-bit
// saturating counters; otherwise both outputs are tied to 0.
module packet_commit_buffer
  import packet_buffer_pkg::*;
#(
  parameter int pDATA_WIDTH        = 8,
  parameter int pDEPTH_RAM         = 4096,
  parameter int pLEN_WIDTH         = 16,
  parameter int pDESC_DEPTH        = 64,
  parameter int pMAX_PACKET_LENGTH = 1536,
  parameter int pMIN_PACKET_LENGTH = 64
) (
  input  logic                   iclk,
  input  logic                   i_rst_n,
  input  logic                   idv,
  input  logic [pDATA_WIDTH-1:0] irx_d,
  input  logic                   irx_er,
  input  logic                   icrc_valid,
  input  logic                   icrc_ok,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [pDATA_WIDTH-1:0] o_data,
  output logic                   o_last,
  output logic [pLEN_WIDTH-1:0]  o_len,
  output logic                   oempty,
  output logic                   ofull,
  output logic [15:0]            o_pkt_cnt,
  output logic [15:0]            o_drop_cnt
);
  localparam int                    P_PTR_W   = ptr_width(pDEPTH_RAM);
  localparam int                    P_AW      = P_PTR_W - 1;
  localparam logic [P_PTR_W-1:0]    P_DEPTH   = P_PTR_W'(pDEPTH_RAM);
  localparam logic [P_PTR_W-1:0]    P_MAX_PTR = P_PTR_W'(pMAX_PACKET_LENGTH);
  localparam logic [pLEN_WIDTH-1:0] P_MAX_LEN = pLEN_WIDTH'(pMAX_PACKET_LENGTH);
  localparam logic [pLEN_WIDTH-1:0] P_MIN_LEN = pLEN_WIDTH'(pMIN_PACKET_LENGTH);

  wr_state_t r_wstate, w_wstate_next;
  rd_state_t r_rstate, w_rstate_next;

  logic [P_PTR_W-1:0]     r_wr_now, r_wr_succ, r_rd_now, r_rd_succ;
  logic [P_PTR_W-1:0]     w_used, w_free;
  logic [pLEN_WIDTH-1:0]  r_len;
  logic                   w_we, w_commit, w_rollback, w_drop_inc;
  logic                   w_desc_full, w_desc_empty, w_pop, w_xfer;
  logic [pLEN_WIDTH-1:0]  w_desc_len;
  logic [$clog2(pDESC_DEPTH):0] w_unused_desc_count;
  logic [P_AW-1:0]        w_raddr;
  logic [pDATA_WIDTH-1:0] r_ram [pDEPTH_RAM];
  logic [pDATA_WIDTH-1:0] r_ram_q, r_odata;
  logic [pLEN_WIDTH-1:0]  r_olen, r_left;
  logic                   r_ovalid, r_olast;

  // Occupancy counts speculative bytes against the oldest unreleased frame.
  assign w_used = r_wr_now - r_rd_succ;
  assign w_free = P_DEPTH - w_used;
  assign ofull  = (w_free < P_MAX_PTR);
  assign oempty = w_desc_empty;

  // ---------------- write FSM ----------------
  always_comb begin
    w_wstate_next = r_wstate;
    w_we          = 1'b0;
    w_commit      = 1'b0;
    w_rollback    = 1'b0;
    w_drop_inc    = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (idv) begin
          if (ofull || w_desc_full || irx_er) begin
            w_wstate_next = W_DROP;
            w_drop_inc    = 1'b1;
          end else begin
            w_we          = 1'b1;
            w_wstate_next = W_WRITE;
          end
        end
      end
      W_WRITE: begin
        if (idv) begin
          // r_len == max means this beat would be max+1; it is not written.
          if (irx_er || (r_len == P_MAX_LEN) || (w_free == '0)) begin
            w_wstate_next = W_DROP;
            w_drop_inc    = 1'b1;
          end else begin
            w_we = 1'b1;
          end
        end else begin
          w_wstate_next = W_WAIT_CRC;
        end
      end
      W_WAIT_CRC: begin
        if (icrc_valid) begin
          if (icrc_ok && (r_len >= P_MIN_LEN)) begin
            w_commit = 1'b1;
          end else begin
            w_rollback = 1'b1;
            w_drop_inc = 1'b1;
          end
          // A frame already starting alongside the verdict has lost its
          // first beat, so it is discarded without a separate count.
          w_wstate_next = idv ? W_DROP : W_IDLE;
        end else if (idv) begin
          w_rollback    = 1'b1;
          w_drop_inc    = 1'b1;
          w_wstate_next = W_DROP;
        end
      end
      W_DROP: begin
        w_rollback = 1'b1;
        if (!idv) w_wstate_next = W_IDLE;
      end
      default: w_wstate_next = W_IDLE;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (!i_rst_n) begin
      r_wstate  <= W_IDLE;
      r_wr_now  <= '0;
      r_wr_succ <= '0;
      r_len     <= '0;
    end else begin
      r_wstate <= w_wstate_next;
      if (w_we) begin
        r_wr_now <= r_wr_now + P_PTR_W'(1);
        r_len    <= (r_wstate == W_IDLE) ? pLEN_WIDTH'(1) : r_len + pLEN_WIDTH'(1);
      end
      if (w_commit)   r_wr_succ <= r_wr_now;
      if (w_rollback) r_wr_now  <= r_wr_succ;
    end
  end

  pkt_desc_fifo #(
    .pWIDTH (pLEN_WIDTH),
    .pDEPTH (pDESC_DEPTH)
  ) u_desc_fifo (
    .iclk    (iclk),
    .i_rst_n (i_rst_n),
    .i_push  (w_commit),
    .i_wdata (r_len),
    .i_pop   (w_pop),
    .o_rdata (w_desc_len),
    .o_full  (w_desc_full),
    .o_empty (w_desc_empty),
    .o_count (w_unused_desc_count)
  );

  // ---------------- read FSM ----------------
  assign w_xfer = r_ovalid & i_ready;

  // The RAM output always holds the beat after the one on o_data, so a
  // transfer loads o_data from r_ram_q and fetches two ahead of rd_now.
  always_comb begin
    w_rstate_next = r_rstate;
    w_pop         = 1'b0;
    w_raddr       = r_rd_now[P_AW-1:0] + P_AW'(1);
    case (r_rstate)
      R_IDLE: begin
        w_raddr = r_rd_now[P_AW-1:0];
        if (!w_desc_empty) begin
          w_pop         = 1'b1;
          w_rstate_next = R_LOAD;
        end
      end
      R_LOAD: w_rstate_next = R_STREAM;
      R_STREAM: begin
        if (w_xfer) begin
          w_raddr = r_rd_now[P_AW-1:0] + P_AW'(2);
          if (r_olast) w_rstate_next = R_IDLE;
        end
      end
      default: w_rstate_next = R_IDLE;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (!i_rst_n) begin
      r_rstate  <= R_IDLE;
      r_rd_now  <= '0;
      r_rd_succ <= '0;
      r_odata   <= '0;
      r_olen    <= '0;
      r_left    <= '0;
      r_ovalid  <= 1'b0;
      r_olast   <= 1'b0;
    end else begin
      r_rstate <= w_rstate_next;
      case (r_rstate)
        R_LOAD: begin
          r_olen   <= w_desc_len;
          r_left   <= w_desc_len - pLEN_WIDTH'(1);
          r_olast  <= (w_desc_len == pLEN_WIDTH'(1));
          r_odata  <= r_ram_q;
          r_ovalid <= 1'b1;
        end
        R_STREAM: begin
          if (w_xfer) begin
            r_rd_now <= r_rd_now + P_PTR_W'(1);
            if (r_olast) begin
              r_rd_succ <= r_rd_now + P_PTR_W'(1);
              r_ovalid  <= 1'b0;
              r_olast   <= 1'b0;
            end else begin
              r_odata <= r_ram_q;
              r_left  <= r_left - pLEN_WIDTH'(1);
              r_olast <= (r_left == pLEN_WIDTH'(1));
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_valid = r_ovalid;
  assign o_data  = r_odata;
  assign o_last  = r_olast;
  assign o_len   = r_olen;

  // ---------------- data RAM ----------------
  always_ff @(posedge iclk) begin
    if (w_we) r_ram[r_wr_now[P_AW-1:0]] <= irx_d;
    r_ram_q <= r_ram[w_raddr];
  end

  // ---------------- statistics ----------------
`ifdef PKT_BUF_STATS_EN
  logic [15:0] r_pkt_cnt, r_drop_cnt;

  always_ff @(posedge iclk) begin
    if (!i_rst_n) begin
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_commit && (r_pkt_cnt != STAT_SAT))
        r_pkt_cnt <= r_pkt_cnt + 16'd1;
      if (w_drop_inc && (r_drop_cnt != STAT_SAT))
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign o_pkt_cnt  = r_pkt_cnt;
  assign o_drop_cnt = r_drop_cnt;
`else
  logic w_unused_stats;
  assign w_unused_stats = w_drop_inc;
  assign o_pkt_cnt      = '0;
  assign o_drop_cnt     = '0;
`endif

endmodule

// File: tb/tb_packet_commit_buffer.sv
module tb_packet_commit_buffer;
  localparam int DEPTH = 4096;
  localparam int MAXL  = 1536;
  localparam int MINL  = 64;
`ifdef PKT_BUF_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        iclk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        idv = 1'b0;
  logic [7:0]  irx_d = '0;
  logic        irx_er = 1'b0;
  logic        icrc_valid = 1'b0;
  logic        icrc_ok = 1'b0;
  logic        i_ready = 1'b0;
  logic        o_valid, o_last, oempty, ofull;
  logic [7:0]  o_data;
  logic [15:0] o_len, o_pkt_cnt, o_drop_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model: expected byte stream and frame lengths, bytes held.
  byte unsigned exp_q[$];
  int           exp_len_q[$];
  int           stored = 0;
  int           m_pkt = 0;
  int           m_drop = 0;
  int           beat_idx = 0;
  int           frames_read = 0;
  int           beats_read = 0;
  int           ready_mode = 1;   // 0 low, 1 high, 2 random

  always #5 iclk = ~iclk;

  packet_commit_buffer dut (
    .iclk       (iclk),
    .i_rst_n    (i_rst_n),
    .idv        (idv),
    .irx_d      (irx_d),
    .irx_er     (irx_er),
    .icrc_valid (icrc_valid),
    .icrc_ok    (icrc_ok),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_last     (o_last),
    .o_len      (o_len),
    .oempty     (oempty),
    .ofull      (ofull),
    .o_pkt_cnt  (o_pkt_cnt),
    .o_drop_cnt (o_drop_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic chk_counters(input string name);
    chk({name, "_pkt_cnt"}, o_pkt_cnt, 64'(STATS * m_pkt));
    chk({name, "_drop_cnt"}, o_drop_cnt, 64'(STATS * m_drop));
  endtask

  // Consumer ready driver.
  initial begin
    forever begin
      @(posedge iclk); #1;
      case (ready_mode)
        0:       i_ready = 1'b0;
        1:       i_ready = 1'b1;
        default: i_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Compare process: every transferred beat against the model, and
  // output stability across every stalled cycle.
  initial begin
    logic        prev_stall;
    logic [7:0]  pd;
    logic        pl;
    logic [15:0] plen;
    prev_stall = 1'b0;
    pd = '0; pl = 1'b0; plen = '0;
    forever begin
      @(negedge iclk);
      if (!i_rst_n) begin
        prev_stall = 1'b0;
        beat_idx   = 0;
        continue;
      end
      if (prev_stall) begin
        chk("hold_valid", o_valid, 1);
        chk("hold_data", o_data, pd);
        chk("hold_last", o_last, pl);
        chk("hold_len", o_len, plen);
      end
      if (o_valid && i_ready) begin
        if (exp_len_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got data %0d expected no beat", o_data);
        end else begin
          chk("beat_data", o_data, exp_q[0]);
          void'(exp_q.pop_front());
          chk("beat_len", o_len, exp_len_q[0]);
          chk("beat_last", o_last, (beat_idx == exp_len_q[0] - 1));
          beats_read++;
          if (beat_idx == exp_len_q[0] - 1) begin
            stored -= exp_len_q[0];
            void'(exp_len_q.pop_front());
            beat_idx = 0;
            frames_read++;
          end else begin
            beat_idx++;
          end
        end
      end
      prev_stall = o_valid && !i_ready;
      pd   = o_data;
      pl   = o_last;
      plen = o_len;
    end
  end

  task automatic do_reset();
    @(posedge iclk); #1;
    i_rst_n = 1'b0; idv = 1'b0; irx_er = 1'b0; icrc_valid = 1'b0; icrc_ok = 1'b0;
    exp_q.delete(); exp_len_q.delete();
    stored = 0; m_pkt = 0; m_drop = 0; frames_read = 0; beats_read = 0;
    repeat (3) @(posedge iclk);
    #1 i_rst_n = 1'b1;
  endtask

  // Drives one frame plus its CRC verdict and predicts its fate.
  task automatic send_frame(input int len, input int err_beat, input bit crc_good,
                            input int crc_delay, input bit tcheck);
    byte unsigned data[$];
    bit accept;
    @(posedge iclk); #1;
    accept = ((DEPTH - stored) >= MAXL);
    for (int i = 1; i <= len; i++) begin
      if (i > 1) begin @(posedge iclk); #1; end
      idv    = 1'b1;
      irx_d  = 8'($urandom_range(0, 255));
      irx_er = (i == err_beat);
      data.push_back(irx_d);
    end
    @(posedge iclk); #1;
    idv = 1'b0; irx_er = 1'b0;
    if (err_beat > 0 && err_beat <= len) accept = 0;
    if (len > MAXL) accept = 0;
    if (!crc_good || len < MINL) accept = 0;
    repeat (crc_delay) @(posedge iclk);
    #1;
    icrc_valid = 1'b1;
    icrc_ok    = crc_good;
    if (accept) begin
      foreach (data[k]) exp_q.push_back(data[k]);
      exp_len_q.push_back(len);
      stored += len;
      m_pkt++;
    end else begin
      m_drop++;
    end
    @(posedge iclk); #1;
    icrc_valid = 1'b0; icrc_ok = 1'b0;
    if (tcheck) begin
      chk("commit_oempty", oempty, 0);
      chk("commit_valid_c0", o_valid, 0);
      @(posedge iclk); #1;
      chk("commit_valid_c1", o_valid, 0);
      @(posedge iclk); #1;
      chk("commit_valid_c2", o_valid, 1);
      chk("first_len", o_len, 64);
    end else begin
      repeat (2) @(posedge iclk);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_len_q.size() != 0 && n < budget) begin
      @(posedge iclk);
      n++;
    end
    checks++;
    if (exp_len_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d frames still pending, required 0", name, exp_len_q.size());
    end
    repeat (3) @(posedge iclk);
    #1;
  endtask

  initial begin
    int rl, re;
    bit rc;
    // Reset state.
    repeat (3) @(posedge iclk);
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_last", o_last, 0);
    chk("rst_len", o_len, 0);
    chk("rst_oempty", oempty, 1);
    chk("rst_ofull", ofull, 0);
    chk("rst_pkt_cnt", o_pkt_cnt, 0);
    chk("rst_drop_cnt", o_drop_cnt, 0);
    i_rst_n = 1'b1;

    // T1: one good 64-beat frame, consumer always ready.
    ready_mode = 1;
    send_frame(64, 0, 1'b1, 2, 1'b1);
    wait_drain("t1", 500);
    chk("t1_frames", frames_read, 1);
    chk("t1_beats", beats_read, 64);
    chk("t1_oempty", oempty, 1);
    chk("t1_pkt_lit", o_pkt_cnt, STATS * 1);
    chk_counters("t1");

    // T2: bad CRC frame then good frame.
    do_reset();
    send_frame(100, 0, 1'b0, 1, 1'b0);
    send_frame(64, 0, 1'b1, 3, 1'b0);
    wait_drain("t2", 500);
    chk("t2_frames", frames_read, 1);
    chk("t2_drop_lit", o_drop_cnt, STATS * 1);
    chk_counters("t2");

    // T3: receive error on beat 10, then a good frame after the rollback.
    do_reset();
    send_frame(80, 10, 1'b1, 2, 1'b0);
    chk("t3_oempty", oempty, 1);
    chk("t3_valid", o_valid, 0);
    chk("t3_drop_lit", o_drop_cnt, STATS * 1);
    send_frame(70, 0, 1'b1, 1, 1'b0);
    wait_drain("t3", 500);
    chk("t3_frames", frames_read, 1);
    chk_counters("t3");

    // T4: oversize frame and runt frame.
    do_reset();
    send_frame(1537, 0, 1'b1, 2, 1'b0);
    send_frame(63, 0, 1'b1, 2, 1'b0);
    chk("t4_drop_lit", o_drop_cnt, STATS * 2);
    chk("t4_oempty", oempty, 1);
    chk_counters("t4");

    // T6: two back-to-back 64-beat frames under random backpressure.
    ready_mode = 2;
    send_frame(64, 0, 1'b1, 1, 1'b0);
    send_frame(64, 0, 1'b1, 1, 1'b0);
    wait_drain("t6", 2000);
    chk("t6_frames", frames_read, 2);
    chk("t6_beats", beats_read, 128);

    // Random mix; also moves pointers away from zero before T5.
    for (int f = 0; f < 16; f++) begin
      rl = $urandom_range(50, 200);
      re = ($urandom_range(0, 9) == 0) ? $urandom_range(2, rl) : 0;
      rc = ($urandom_range(0, 4) != 0);
      send_frame(rl, re, rc, $urandom_range(1, 4), 1'b0);
    end
    wait_drain("rand", 20000);
    chk_counters("rand");

    // T5: stalled reader, three max-length frames; third finds ofull set.
    ready_mode = 0;
    send_frame(1536, 0, 1'b1, 2, 1'b0);
    send_frame(1536, 0, 1'b1, 2, 1'b0);
    chk("t5_ofull", ofull, 1);
    send_frame(1536, 0, 1'b1, 2, 1'b0);
    chk("t5_pending", exp_len_q.size(), 2);
    chk_counters("t5_stalled");
    ready_mode = 2;
    wait_drain("t5", 20000);
    chk("t5_oempty", oempty, 1);
    chk("t5_ofull_after", ofull, 0);
    chk_counters("t5");

    // Reset while a committed frame waits and another is arriving.
    ready_mode = 0;
    send_frame(64, 0, 1'b1, 1, 1'b0);
    @(posedge iclk); #1;
    for (int i = 0; i < 20; i++) begin
      idv = 1'b1;
      irx_d = 8'(i);
      @(posedge iclk); #1;
    end
    do_reset();
    ready_mode = 1;
    repeat (5) @(posedge iclk);
    #1;
    chk("rstmid_oempty", oempty, 1);
    chk("rstmid_valid", o_valid, 0);
    chk_counters("rstmid");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
